// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues PC reads to instruction memory, queues the
// returned words in order with their addresses, and hands them to decode.
module inst_fetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              jump_flag_i,
  output logic              pc_hold_o,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  input  logic              inst_ready_i
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_filled;
  logic [PW-1:0]     r_alloc_ptr, r_fill_ptr, r_head_ptr;
  logic [CW-1:0]     r_alloc_cnt, r_drop_cnt;

  logic          w_pop, w_credit, w_grant, w_fill, w_drop;
  logic [CW:0]   w_used;
  logic [CW-1:0] w_filled_cnt, w_unfilled;

  assign inst_valid_o = r_filled[r_head_ptr] & (r_alloc_cnt != '0) & ~jump_flag_i;
  assign inst_o       = r_data[r_head_ptr];
  assign inst_pc_o    = r_addr[r_head_ptr];
  assign w_pop        = inst_valid_o & inst_ready_i;

  // Counting the slot freed by this cycle's pop keeps one fetch per cycle flowing.
  assign w_used   = {1'b0, r_alloc_cnt} + {1'b0, r_drop_cnt} - {{CW{1'b0}}, w_pop};
  assign w_credit = w_used < LIMIT;

  assign imem_req_o  = rst_ & w_credit & ~jump_flag_i;
  assign imem_addr_o = pc_i;
  assign w_grant     = imem_req_o & imem_gnt_i;
  assign pc_hold_o   = ~rst_ | (~w_grant & ~jump_flag_i);

  assign w_drop = imem_rvalid_i & (r_drop_cnt != '0);
  assign w_fill = imem_rvalid_i & (r_drop_cnt == '0) & ~jump_flag_i;

  always_comb begin
    w_filled_cnt = '0;
    for (int i = 0; i < DEPTH; i++)
      w_filled_cnt = w_filled_cnt + CW'(r_filled[i]);
  end

  // Granted slots still waiting for data; their responses must be dropped on a flush.
  assign w_unfilled = r_alloc_cnt - w_filled_cnt;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
      r_filled    <= '0;
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_head_ptr  <= '0;
      r_alloc_cnt <= '0;
      r_drop_cnt  <= '0;
    end else if (jump_flag_i) begin
      r_filled    <= '0;
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_head_ptr  <= '0;
      r_alloc_cnt <= '0;
      r_drop_cnt  <= r_drop_cnt + w_unfilled - CW'(imem_rvalid_i);
    end else begin
      if (w_grant) begin
        r_addr[r_alloc_ptr] <= pc_i;
        r_alloc_ptr         <= r_alloc_ptr + PW'(1);
      end
      if (w_fill) begin
        r_data[r_fill_ptr] <= imem_rdata_i;
        r_fill_ptr         <= r_fill_ptr + PW'(1);
      end
      if (w_pop)
        r_head_ptr <= r_head_ptr + PW'(1);
      if (w_drop)
        r_drop_cnt <= r_drop_cnt - CW'(1);
      r_alloc_cnt <= r_alloc_cnt + CW'(w_grant) - CW'(w_pop);
      for (int i = 0; i < DEPTH; i++) begin
        if ((w_pop && r_head_ptr == PW'(i)) || (w_grant && r_alloc_ptr == PW'(i)))
          r_filled[i] <= 1'b0;
        if (w_fill && r_fill_ptr == PW'(i))
          r_filled[i] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: per-cycle vectors with hand-computed outputs.
module tb_inst_fetch;
  logic        clk = 1'b0;
  logic        rst_;
  logic [31:0] pc_i;
  logic        jump_flag_i;
  logic        pc_hold_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;

  int n_chk  = 0;
  int n_fail = 0;

  inst_fetch #(.ADDR_W(32), .DATA_W(32), .DEPTH(2)) dut (
    .clk(clk), .rst_(rst_), .pc_i(pc_i), .jump_flag_i(jump_flag_i),
    .pc_hold_o(pc_hold_o), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .inst_ready_i(inst_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        jmp, gnt, rv;
    logic [31:0] rd;
    logic        rdy;
    logic        req, hold, vld;
    logic [31:0] ipc, ins;
  } vec_t;

  function automatic logic [31:0] D(input logic [31:0] a);
    return a ^ 32'hA5A50000;
  endfunction

  function automatic vec_t mk(input logic [31:0] pc, input logic jmp, gnt, rv,
                              input logic [31:0] rd, input logic rdy,
                              input logic req, hold, vld, input logic [31:0] ipc, ins);
    return '{pc, jmp, gnt, rv, rd, rdy, req, hold, vld, ipc, ins};
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, k, act, exp);
    end
  endtask

  task automatic idle();
    jump_flag_i = 0; imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0; inst_ready_i = 0;
  endtask

  // Drive one cycle's inputs after the falling edge and check the outputs before the rising edge.
  task automatic apply(input vec_t v, input string nm, input int k);
    @(negedge clk);
    pc_i = v.pc; jump_flag_i = v.jmp; imem_gnt_i = v.gnt; imem_rvalid_i = v.rv;
    imem_rdata_i = v.rd; inst_ready_i = v.rdy;
    #1;
    chk({nm, ".req"},  k, 32'(imem_req_o),   32'(v.req));
    chk({nm, ".hold"}, k, 32'(pc_hold_o),    32'(v.hold));
    chk({nm, ".vld"},  k, 32'(inst_valid_o), 32'(v.vld));
    chk({nm, ".addr"}, k, imem_addr_o, v.pc);
    if (v.vld) begin
      chk({nm, ".ipc"}, k, inst_pc_o, v.ipc);
      chk({nm, ".ins"}, k, inst_o, v.ins);
    end
  endtask

  vec_t tbl [9];
  vec_t seq [$];

  initial begin
    rst_ = 0; pc_i = 0; idle();

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pc_i = $urandom; jump_flag_i = 1'($urandom_range(0, 1)); imem_gnt_i = 1'($urandom_range(0, 1));
      imem_rvalid_i = 1'($urandom_range(0, 1)); imem_rdata_i = $urandom;
      inst_ready_i = 1'($urandom_range(0, 1));
      #1;
      chk("rst.req",  i, 32'(imem_req_o),   0);
      chk("rst.vld",  i, 32'(inst_valid_o), 0);
      chk("rst.hold", i, 32'(pc_hold_o),    1);
      chk("rst.ipc",  i, inst_pc_o, 0);
      chk("rst.ins",  i, inst_o, 0);
    end
    @(negedge clk);
    idle(); pc_i = 0; rst_ = 1;
    #1;
    chk("first.req",  0, 32'(imem_req_o), 1);
    chk("first.hold", 0, 32'(pc_hold_o),  1);

    // Streaming then drain: pc, jmp, gnt, rv, rdata, rdy | req, hold, vld, ipc, inst
    tbl[0] = mk('h00, 0, 1, 0, 0,       1, 1, 0, 0, 0,    0);
    tbl[1] = mk('h04, 0, 1, 1, D('h00), 1, 1, 0, 0, 0,    0);
    tbl[2] = mk('h08, 0, 1, 1, D('h04), 1, 1, 0, 1, 'h00, D('h00));
    tbl[3] = mk('h0C, 0, 1, 1, D('h08), 1, 1, 0, 1, 'h04, D('h04));
    tbl[4] = mk('h10, 0, 1, 1, D('h0C), 1, 1, 0, 1, 'h08, D('h08));
    tbl[5] = mk('h14, 0, 0, 1, D('h10), 1, 1, 1, 1, 'h0C, D('h0C));
    tbl[6] = mk('h14, 0, 0, 0, 0,       0, 1, 1, 1, 'h10, D('h10));
    tbl[7] = mk('h14, 0, 0, 0, 0,       1, 1, 1, 1, 'h10, D('h10));
    tbl[8] = mk('h14, 0, 0, 0, 0,       1, 1, 1, 0, 0,    0);
    for (int i = 0; i < 9; i++) apply(tbl[i], "stream", i);

    // Backpressure: queue fills after two grants, then drains without loss
    seq = {};
    seq.push_back(mk('h00, 0, 1, 0, 0,       0, 1, 0, 0, 0,    0));
    seq.push_back(mk('h04, 0, 1, 1, D('h00), 0, 1, 0, 0, 0,    0));
    seq.push_back(mk('h08, 0, 1, 1, D('h04), 0, 0, 1, 1, 'h00, D('h00)));
    seq.push_back(mk('h08, 0, 1, 0, 0,       0, 0, 1, 1, 'h00, D('h00)));
    seq.push_back(mk('h08, 0, 1, 0, 0,       1, 1, 0, 1, 'h00, D('h00)));
    seq.push_back(mk('h0C, 0, 0, 1, D('h08), 1, 1, 1, 1, 'h04, D('h04)));
    seq.push_back(mk('h0C, 0, 0, 0, 0,       1, 1, 1, 1, 'h08, D('h08)));
    seq.push_back(mk('h0C, 0, 0, 0, 0,       1, 1, 1, 0, 0,    0));
    foreach (seq[i]) apply(seq[i], "bp", i);

    // Grant stall: request and address held for three cycles
    seq = {};
    for (int i = 0; i < 3; i++) seq.push_back(mk('h10, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0));
    seq.push_back(mk('h10, 0, 1, 0, 0,       1, 1, 0, 0, 0,    0));
    seq.push_back(mk('h14, 0, 0, 1, D('h10), 1, 1, 1, 0, 0,    0));
    seq.push_back(mk('h14, 0, 0, 0, 0,       1, 1, 1, 1, 'h10, D('h10)));
    seq.push_back(mk('h14, 0, 0, 0, 0,       1, 1, 1, 0, 0,    0));
    foreach (seq[i]) apply(seq[i], "stall", i);

    // Jump with two fetches outstanding, then a jump over a filled head
    seq = {};
    seq.push_back(mk('h020, 0, 1, 0, 0,        1, 1, 0, 0, 0,     0));
    seq.push_back(mk('h024, 0, 1, 0, 0,        1, 1, 0, 0, 0,     0));
    seq.push_back(mk('h028, 1, 1, 0, 0,        1, 0, 0, 0, 0,     0));
    seq.push_back(mk('h100, 0, 0, 0, 0,        1, 0, 1, 0, 0,     0));
    seq.push_back(mk('h100, 0, 0, 1, D('h020), 1, 0, 1, 0, 0,     0));
    seq.push_back(mk('h100, 0, 0, 1, D('h024), 1, 1, 1, 0, 0,     0));
    seq.push_back(mk('h100, 0, 1, 0, 0,        1, 1, 0, 0, 0,     0));
    seq.push_back(mk('h104, 0, 0, 1, D('h100), 1, 1, 1, 0, 0,     0));
    seq.push_back(mk('h104, 0, 0, 0, 0,        0, 1, 1, 1, 'h100, D('h100)));
    seq.push_back(mk('h104, 1, 0, 0, 0,        1, 0, 0, 0, 0,     0));
    seq.push_back(mk('h200, 0, 0, 0, 0,        1, 1, 1, 0, 0,     0));
    foreach (seq[i]) apply(seq[i], "jump", i);

    // Fill the queue, then reset asynchronously
    seq = {};
    seq.push_back(mk('h200, 0, 1, 0, 0,        0, 1, 0, 0, 0,     0));
    seq.push_back(mk('h204, 0, 1, 1, D('h200), 0, 1, 0, 0, 0,     0));
    seq.push_back(mk('h208, 0, 1, 1, D('h204), 0, 0, 1, 1, 'h200, D('h200)));
    foreach (seq[i]) apply(seq[i], "full", i);
    #2 rst_ = 0;
    #1;
    chk("mrst.req",  0, 32'(imem_req_o),   0);
    chk("mrst.vld",  0, 32'(inst_valid_o), 0);
    chk("mrst.hold", 0, 32'(pc_hold_o),    1);
    chk("mrst.ipc",  0, inst_pc_o, 0);
    chk("mrst.ins",  0, inst_o, 0);
    @(negedge clk); idle(); pc_i = 0;
    @(negedge clk); rst_ = 1;

    seq = {};
    seq.push_back(mk('h00, 0, 1, 0, 0,       1, 1, 0, 0, 0,    0));
    seq.push_back(mk('h04, 0, 1, 1, D('h00), 1, 1, 0, 0, 0,    0));
    seq.push_back(mk('h08, 0, 0, 1, D('h04), 1, 1, 1, 1, 'h00, D('h00)));
    seq.push_back(mk('h08, 0, 0, 0, 0,       1, 1, 1, 1, 'h04, D('h04)));
    seq.push_back(mk('h08, 0, 0, 0, 0,       1, 1, 1, 0, 0,    0));
    foreach (seq[i]) apply(seq[i], "restart", i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage between the program counter register and the decode stage. Each cycle it issues a read of the address on `pc_i` to instruction memory through a request/grant/response handshake. It buffers returned words together with their addresses in a small in-order queue and presents them to decode through a valid/ready handshake. It drives `pc_hold_o` back to the program counter so the PC advances only when a fetch is accepted, and it discards in-flight fetches when a jump occurs.

## Interface
- `ADDR_W`, default 32: address width; `pc_i` and `inst_pc_o` width.
- `DATA_W`, default 32: instruction word width.
- `DEPTH`, default 2: queue slots and maximum outstanding fetches. Must be a power of two, ≥ 2.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock; all state updates on its rising edge.
- `rst_` in 1: asynchronous active-low reset.
- `pc_i` in ADDR_W: current PC, the fetch address.
- `jump_flag_i` in 1: jump this cycle; flushes the fetch stage.
- `pc_hold_o` out 1: 1 tells the PC register not to advance this cycle.
- `imem_req_o` out 1: fetch request.
- `imem_addr_o` out ADDR_W: fetch address, equal to `pc_i`.
- `imem_gnt_i` in 1: request accepted this cycle.
- `imem_rvalid_i` in 1: response valid. Responses arrive in order, at least 1 cycle after their grant.
- `imem_rdata_i` in DATA_W: response word.
- `inst_valid_o` out 1: instruction available to decode.
- `inst_o` out DATA_W: instruction word at the queue head.
- `inst_pc_o` out ADDR_W: address of `inst_o`.
- `inst_ready_i` in 1: decode accepts the head this cycle.

## Operation
- **Queue.** `DEPTH` slots; each slot holds addr, data, and a `filled` bit.
  - Pointers: alloc, fill, head.
  - Counters: `alloc_cnt` (slots in use) and `drop_cnt` (responses still to discard), each `$clog2(DEPTH)+1` bits.
- **Consume.** `pop = inst_valid_o & inst_ready_i`.
  - `inst_valid_o = head.filled & (alloc_cnt != 0) & ~jump_flag_i`.
  - `inst_o` and `inst_pc_o` come from the head slot.
  - On `pop`: clear head `filled`, increment head, decrement `alloc_cnt`.
- **Credit.** `credit = (alloc_cnt - pop + drop_cnt) < DEPTH`. This is combinational from `inst_ready_i`, which allows 1 fetch per cycle in steady state.
- **Request.** `imem_req_o = credit & ~jump_flag_i`; `imem_addr_o = pc_i`.
  - On `imem_req_o & imem_gnt_i`: write `pc_i` into the alloc slot with `filled=0`, increment alloc and `alloc_cnt`.
- **Hold.** `pc_hold_o = ~(imem_req_o & imem_gnt_i) & ~jump_flag_i`. The PC advances only on an accepted fetch or on a jump.
- **Response.** On `imem_rvalid_i`:
  - If `drop_cnt != 0`: decrement `drop_cnt` and discard the data.
  - Otherwise: write `imem_rdata_i` into the fill slot, set `filled`, increment fill.
- **Flush.** On `jump_flag_i=1`:
  - No request is issued and `inst_valid_o` is 0.
  - Next state: queue emptied (`alloc_cnt`=0, all pointers equal, all `filled` cleared).
  - `drop_cnt` becomes (granted-but-unfilled slots) + (`drop_cnt`), minus 1 if a response arrives in that same cycle.
- **Simultaneous events.**
  - Grant, response and pop in one cycle are all applied.
  - Fill into the slot being allocated is impossible, because a response always lags its grant.
- **No bypass.** Response data reaches `inst_o` only after it is written into the queue.
- **Stable request.** A request held without grant keeps `imem_addr_o` stable, because `pc_hold_o=1` keeps `pc_i` constant.

## Timing
- **Reset values:**
  - `imem_req_o`=0, `inst_valid_o`=0, `pc_hold_o`=1.
  - `inst_o`=0, `inst_pc_o`=0.
  - All counters and pointers 0; all slots cleared.
  - `imem_addr_o` follows `pc_i`.
- **First request.** `imem_req_o` rises combinationally in the first cycle after `rst_` deasserts.
- **Latency.** Grant in cycle N with rvalid in N+k (k≥1) gives `inst_valid_o` in N+k+1.
- **Throughput.** With gnt=1, 1-cycle rvalid and ready=1: 1 instruction per cycle after a 2-cycle start-up.
- **Backpressure.** With ready=0, at most `DEPTH` fetches are granted. After that, `imem_req_o`=0 and `pc_hold_o`=1 until a pop.
- **Reset mid-operation.** Clears everything immediately, including `drop_cnt`. Memory is reset alongside, so no stale responses follow.

## Test plan
- **Reset.** `rst_`=0 with random inputs -> `imem_req_o`=0, `inst_valid_o`=0, `pc_hold_o`=1, `inst_pc_o`=0.
- **Streaming.**
  - Stimulus: PC model from 0; gnt=1; rvalid 1 cycle after grant with rdata=addr^32'hA5A50000; ready=1.
  - Response: `inst_pc_o` 0,4,8,C,… on consecutive cycles, first valid 2 cycles after first grant, data matching; `pc_hold_o`=0 throughout.
- **Backpressure.**
  - Stimulus: ready=0 after the pc 0 fetch.
  - Response: only 0 and 4 are granted; `imem_req_o`=0; `pc_i` stays 8; `pc_hold_o`=1.
  - Then ready=1 -> 0,4,8 delivered with no loss or duplicate.
- **Grant stall.**
  - Stimulus: gnt=0 for 3 cycles at pc 0x10.
  - Response: `imem_req_o`=1 and `imem_addr_o`=0x10 stable, `pc_hold_o`=1; then fetch 0x10 once.
- **Jump flush.**
  - Stimulus: 2 fetches (0x20, 0x24) outstanding; `jump_flag_i`=1 with target 0x100; responses arrive 2 and 3 cycles later.
  - Response: both responses discarded; first `inst_valid_o` has `inst_pc_o`=0x100; no 0x20/0x24 ever presented.
- **Reset mid-operation.**
  - Stimulus: `rst_`=0 asynchronously while the queue is full, then released with the PC at 0.
  - Response: outputs immediately at reset values; afterwards the stream restarts at `inst_pc_o`=0.
